rc4_crack_ctrl: RTL and testbench
=================================

# rc4_crack_ctrl

Top-level sequencer and memory arbiter for the RC4 key-search datapath. Per candidate key it resets and runs three stages in order: S-memory init fill, key-scheduling swap, PRGA/decrypt-check. It grants the single-port S memory (address/data/wren) to exactly one stage at a time, and advances the 24-bit secret key until a key passes or the search range is exhausted.

## Interface
- `KEY_MIN`, 24'h000000, first key tried
- `KEY_MAX`, 24'h3FFFFF, last key tried (inclusive)
- `TIMEOUT_CYCLES`, 4096, per-stage watchdog limit (used only with `STAGE_TIMEOUT_EN`)
- `clk`  in  1  sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level sampled in IDLE/FOUND/EXHAUSTED/ERROR; begins a search from `KEY_MIN`
- `busy`  out  1  high from the cycle after `start` is accepted until a terminal state
- `done`  out  1  high in FOUND, EXHAUSTED and ERROR
- `success`  out  1  high only in FOUND
- `secret_key`  out  24  candidate key driven to all stages; holds the passing/last key at termination
- `sub_reset`  out  1  active-high one-cycle reset to all stages (they hold their done flags until reset)
- `stage_start`  out  3  one-cycle start pulse per stage; bit0 init, bit1 ksa, bit2 prga
- `stage_done`  in  3  stage done flags, same indexing; level or pulse
- `prga_pass`  in  1  decrypt-check verdict, valid with `stage_done[2]`
- `stage_addr`  in  24  {prga, ksa, init} 8-bit addresses
- `stage_data`  in  24  {prga, ksa, init} 8-bit write data
- `stage_wren`  in  3  per-stage write enables
- `mem_addr` / `mem_data` / `mem_wren`  out  8/8/1  to S memory
- `error`  out  1  watchdog abort; present only with `STAGE_TIMEOUT_EN`

## Operation
- States: IDLE, SUB_RESET, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, CHECK, FOUND, EXHAUSTED, ERROR.
- IDLE/terminal + `start` -> SUB_RESET, `secret_key` <= `KEY_MIN`. `start` while busy is ignored.
- SUB_RESET: `sub_reset`=1 for 1 cycle -> INIT_GO.
- x_GO: matching `stage_start` bit =1 for 1 cycle, grant = that stage -> x_WAIT.
- x_WAIT: grant held. Only the granted stage's `stage_done` bit is sampled; the others are ignored. Done -> next GO (INIT->KSA->PRGA). PRGA_WAIT captures `prga_pass` on done -> CHECK.
- CHECK: pass -> FOUND; else `secret_key`==`KEY_MAX` -> EXHAUSTED; else `secret_key`+1 -> SUB_RESET. No wrap past `KEY_MAX`.
- Grant is decoded from the state register. `mem_*` = granted stage's signals. With no grant (IDLE, SUB_RESET, CHECK, terminals): `mem_wren`=0, `mem_addr`=0, `mem_data`=0.
- A stale done arriving in a GO state is ignored; it is sampled from the following WAIT cycle.
- `reset_n` low at any time: state IDLE, `secret_key`=`KEY_MIN`, all outputs 0. The search restarts only on a new `start`.

## Timing
- Reset values: `busy`, `done`, `success`, `sub_reset`, `stage_start`, `mem_*`, `error` = 0. `secret_key` = `KEY_MIN`.
- All control outputs are registered or decoded from the state register. The `mem_*` path is a combinational mux with zero added latency.
- Controller overhead per key is 5 cycles (SUB_RESET, 3 GO, CHECK), plus 1 cycle per stage from its done to the next GO.
- `done`/`success` assert the cycle after CHECK and hold until `start` or reset.

## Configuration
- `STAGE_TIMEOUT_EN` defined: a 16-bit counter clears in each GO state and increments in WAIT. When it reaches `TIMEOUT_CYCLES` -> ERROR with `error`=1 and `done`=1. `start` clears ERROR.
- Undefined: no counter, no `error` port, and WAIT states wait indefinitely.

## Structure
- `rc4_ctrl_pkg`: state enum, grant enum (NONE/INIT/KSA/PRGA), stage index constants, and key width 24.
- Sub-module `rc4_mem_mux`: grant-selected 3:1 mux for addr/data/wren, with wren forced 0 on NONE.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0, `secret_key`=0, `mem_wren`=0.
- Stub stages (done 20 cycles after start), `prga_pass`=1 on key 0 -> FOUND, `success`=1, `secret_key`=0, exactly one `sub_reset` pulse.
- `prga_pass`=1 only on key 5 -> `secret_key`=5, 6 `sub_reset` pulses, and the `stage_start` order is init, ksa, prga each round.
- `KEY_MAX`=3 with pass always 0 -> EXHAUSTED after 4 rounds, `success`=0, `secret_key`=3.
- During INIT_WAIT drive `stage_wren`=3'b110 with ksa addr 8'h55 -> `mem_wren`=0 and `mem_addr`=init addr. A ksa done pulse there is ignored.
- `reset_n` low mid-KSA_WAIT -> IDLE next edge, `busy`=0. With `STAGE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, init never done -> `error`=1 after 100 WAIT cycles.

Source files
------------

// File: rtl/rc4_ctrl_pkg.sv
// rc4_ctrl_pkg
// Shared types for the RC4 key-search controller: controller state
// encoding, memory grant encoding, stage bit indices and key width.
// The grant is a pure function of the controller state, so it lives here.
// That way the top and any debug logic decode it the same way.
package rc4_ctrl_pkg;

  localparam int KEY_W      = 24;
  localparam int NUM_STAGES = 3;
  localparam int STAGE_INIT = 0;
  localparam int STAGE_KSA  = 1;
  localparam int STAGE_PRGA = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SUB_RESET,
    ST_INIT_GO,
    ST_INIT_WAIT,
    ST_KSA_GO,
    ST_KSA_WAIT,
    ST_PRGA_GO,
    ST_PRGA_WAIT,
    ST_CHECK,
    ST_FOUND,
    ST_EXHAUSTED,
    ST_ERROR
  } ctrl_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_INIT,
    GRANT_KSA,
    GRANT_PRGA
  } grant_t;

  // A stage owns the S memory from its GO cycle through the end of its WAIT.
  function automatic grant_t state_grant(input ctrl_state_t s);
    case (s)
      ST_INIT_GO, ST_INIT_WAIT: return GRANT_INIT;
      ST_KSA_GO,  ST_KSA_WAIT:  return GRANT_KSA;
      ST_PRGA_GO, ST_PRGA_WAIT: return GRANT_PRGA;
      default:                  return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rc4_mem_mux.sv
// rc4_mem_mux
// Grant-selected 3:1 mux that connects one stage to the single-port S memory.
// Ports:
//   grant       which stage owns the memory (NONE drives all zeros)
//   stage_addr  {prga, ksa, init} 8-bit addresses
//   stage_data  {prga, ksa, init} 8-bit write data
//   stage_wren  per-stage write enables, same indexing
//   mem_addr / mem_data / mem_wren  to the S memory
// This block is purely combinational, so it adds no latency to the memory path.
module rc4_mem_mux
  import rc4_ctrl_pkg::*;
(
  input  grant_t      grant,
  input  logic [23:0] stage_addr,
  input  logic [23:0] stage_data,
  input  logic [2:0]  stage_wren,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wren
);

  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    case (grant)
      GRANT_INIT: begin
        mem_addr = stage_addr[7:0];
        mem_data = stage_data[7:0];
        mem_wren = stage_wren[STAGE_INIT];
      end
      GRANT_KSA: begin
        mem_addr = stage_addr[15:8];
        mem_data = stage_data[15:8];
        mem_wren = stage_wren[STAGE_KSA];
      end
      GRANT_PRGA: begin
        mem_addr = stage_addr[23:16];
        mem_data = stage_data[23:16];
        mem_wren = stage_wren[STAGE_PRGA];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_crack_ctrl.sv
// rc4_crack_ctrl
// Top-level sequencer and S-memory arbiter for the RC4 key search.
// For each candidate key, it resets the stages and then runs three of them
// in order: init fill, KSA swap, and PRGA decrypt-check. It then moves to
// the next key, and stops when a key passes or the range is exhausted.
// Parameters: KEY_MIN, KEY_MAX (inclusive range), TIMEOUT_CYCLES (watchdog).
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  begins a search from KEY_MIN when not busy
//   busy/done/success      search status
//   secret_key             current or final candidate key
//   sub_reset              one-cycle reset pulse to all stages
//   stage_start/stage_done per-stage handshake, bit0 init, bit1 ksa, bit2 prga
//   prga_pass              decrypt verdict, valid with stage_done[2]
//   stage_addr/data/wren   per-stage memory requests
//   mem_addr/data/wren     arbitrated S-memory port
//   error                  watchdog abort (only with STAGE_TIMEOUT_EN)
// Optional feature: define STAGE_TIMEOUT_EN to enable the per-stage watchdog.
module rc4_crack_ctrl
  import rc4_ctrl_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_MIN        = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_MAX        = 24'h3FFFFF,
  parameter int               TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             success,
  output logic [KEY_W-1:0] secret_key,
  output logic             sub_reset,
  output logic [2:0]       stage_start,
  input  logic [2:0]       stage_done,
  input  logic             prga_pass,
  input  logic [23:0]      stage_addr,
  input  logic [23:0]      stage_data,
  input  logic [2:0]       stage_wren,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_data,
  output logic             mem_wren
`ifdef STAGE_TIMEOUT_EN
  ,
  output logic             error
`endif
);

  ctrl_state_t      state, state_next;
  logic [KEY_W-1:0] key_next;
  logic             pass_q, pass_next;
  grant_t           grant;
  logic             granted_done;
  logic             in_go, in_wait;

`ifdef STAGE_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_count, wd_next;
`endif

  assign grant   = state_grant(state);
  assign in_go   = (state == ST_INIT_GO) || (state == ST_KSA_GO) || (state == ST_PRGA_GO);
  assign in_wait = (state == ST_INIT_WAIT) || (state == ST_KSA_WAIT) || (state == ST_PRGA_WAIT);

  // Only the granted stage's done flag matters. A stage left holding done from
  // an earlier phase, or another stage's stray pulse, cannot advance the sequence.
  always_comb begin
    granted_done = 1'b0;
    case (grant)
      GRANT_INIT: granted_done = stage_done[STAGE_INIT];
      GRANT_KSA:  granted_done = stage_done[STAGE_KSA];
      GRANT_PRGA: granted_done = stage_done[STAGE_PRGA];
      default:    granted_done = 1'b0;
    endcase
  end

  // Status and strobe outputs are decoded straight from the state register.
  assign busy        = !((state == ST_IDLE) || (state == ST_FOUND) ||
                         (state == ST_EXHAUSTED) || (state == ST_ERROR));
  assign done        = (state == ST_FOUND) || (state == ST_EXHAUSTED) || (state == ST_ERROR);
  assign success     = (state == ST_FOUND);
  assign sub_reset   = (state == ST_SUB_RESET);
  assign stage_start = {state == ST_PRGA_GO, state == ST_KSA_GO, state == ST_INIT_GO};
`ifdef STAGE_TIMEOUT_EN
  assign error       = (state == ST_ERROR);
`endif

  rc4_mem_mux u_mem_mux (
    .grant      (grant),
    .stage_addr (stage_addr),
    .stage_data (stage_data),
    .stage_wren (stage_wren),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      secret_key <= KEY_MIN;
      pass_q     <= 1'b0;
    end else begin
      state      <= state_next;
      secret_key <= key_next;
      pass_q     <= pass_next;
    end
  end

`ifdef STAGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wd_count <= '0;
    else          wd_count <= wd_next;
  end
`endif

  // GO states always take exactly one cycle. Done is only looked at in WAIT,
  // so a done flag already standing when GO is entered is sampled one cycle later.
  always_comb begin
    state_next = state;
    key_next   = secret_key;
    pass_next  = pass_q;
    case (state)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_ERROR: begin
        if (start) begin
          state_next = ST_SUB_RESET;
          key_next   = KEY_MIN;
        end
      end
      ST_SUB_RESET: state_next = ST_INIT_GO;
      ST_INIT_GO:   state_next = ST_INIT_WAIT;
      ST_INIT_WAIT: if (granted_done) state_next = ST_KSA_GO;
      ST_KSA_GO:    state_next = ST_KSA_WAIT;
      ST_KSA_WAIT:  if (granted_done) state_next = ST_PRGA_GO;
      ST_PRGA_GO:   state_next = ST_PRGA_WAIT;
      ST_PRGA_WAIT: begin
        if (granted_done) begin
          pass_next  = prga_pass;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (pass_q)                    state_next = ST_FOUND;
        else if (secret_key == KEY_MAX) state_next = ST_EXHAUSTED;
        else begin
          key_next   = secret_key + KEY_W'(1);
          state_next = ST_SUB_RESET;
        end
      end
      default: state_next = ST_IDLE;
    endcase

`ifdef STAGE_TIMEOUT_EN
    // The abort fires on the WAIT cycle that would bring the count up to the
    // limit, so a stage gets exactly TIMEOUT_CYCLES WAIT cycles to finish.
    wd_next = wd_count;
    if (in_go) begin
      wd_next = '0;
    end else if (in_wait) begin
      wd_next = wd_count + 16'd1;
      if (!granted_done && (wd_count == WD_LAST)) state_next = ST_ERROR;
    end
`endif
  end

endmodule

// File: tb/tb_rc4_crack_ctrl.sv
// tb_rc4_crack_ctrl
// Testbench for rc4_crack_ctrl. It has two parts:
//   - Hand-driven stage handshakes, plus a vector table that exercises the
//     memory mux while the controller sits in the idle, init and prga states.
//   - Stub stages that answer 20 cycles after each start. These run complete
//     searches: pass on key 0, pass on key 5, and an exhausted range with
//     KEY_MAX=7.
// With STAGE_TIMEOUT_EN defined, it also checks the watchdog with
// TIMEOUT_CYCLES=100.
module tb_rc4_crack_ctrl;

  localparam int STUB_DELAY = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy, done, success, sub_reset, mem_wren;
  logic [23:0] secret_key;
  logic [2:0]  stage_start, stage_done, stage_wren;
  logic        prga_pass;
  logic [23:0] stage_addr, stage_data;
  logic [7:0]  mem_addr, mem_data;
`ifdef STAGE_TIMEOUT_EN
  logic        error;
`endif

  logic [2:0]  man_done;
  logic        man_pass;
  logic [2:0]  stub_done = 3'b000;
  logic        stub_pass = 1'b0;
  logic        stub_en;
  logic [23:0] pass_key;

  int checks = 0;
  int errors = 0;
  int sr_count = 0;
  int order_q[$];
  int stub_cnt[3];
  bit stub_act[3];

  assign stage_done = stub_en ? stub_done : man_done;
  assign prga_pass  = stub_en ? stub_pass : man_pass;

  always #5 clk = ~clk;

  rc4_crack_ctrl #(
    .KEY_MIN        (24'h000000),
    .KEY_MAX        (24'h000007),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .success     (success),
    .secret_key  (secret_key),
    .sub_reset   (sub_reset),
    .stage_start (stage_start),
    .stage_done  (stage_done),
    .prga_pass   (prga_pass),
    .stage_addr  (stage_addr),
    .stage_data  (stage_data),
    .stage_wren  (stage_wren),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren)
`ifdef STAGE_TIMEOUT_EN
    ,
    .error       (error)
`endif
  );

  // Stub stages and the pulse log. Both update on the falling edge, away from
  // the active edge. Each stub raises its done flag as a level STUB_DELAY
  // cycles after its start pulse, and holds it until sub_reset.
  always @(negedge clk) begin
    if (sub_reset) sr_count++;
    for (int i = 0; i < 3; i++) if (stage_start[i]) order_q.push_back(i);
    if (!stub_en || sub_reset) begin
      stub_done = 3'b000;
      for (int i = 0; i < 3; i++) begin
        stub_act[i] = 1'b0;
        stub_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stage_start[i]) begin
          stub_act[i] = 1'b1;
          stub_cnt[i] = 0;
        end else if (stub_act[i] && !stub_done[i]) begin
          stub_cnt[i]++;
          if (stub_cnt[i] == STUB_DELAY) begin
            stub_done[i] = 1'b1;
            if (i == 2) stub_pass = (secret_key == pass_key);
          end
        end
      end
    end
  end

  typedef struct {
    int          phase;
    logic [2:0]  wren;
    logic [23:0] addr;
    logic [23:0] data;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_data;
    logic        exp_wren;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] wren, input logic [23:0] addr, input logic [23:0] data);
    @(negedge clk);
    stage_wren = wren;
    stage_addr = addr;
    stage_data = data;
    #1;
  endtask

  // Phase 0 = idle, 1 = INIT_WAIT, 2 = PRGA_WAIT. The done inputs stay low,
  // so the controller does not move while these vectors are applied.
  task automatic runPhase(input int phase);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].phase == phase) begin
        applyStimulus(vecs[i].wren, vecs[i].addr, vecs[i].data);
        checkOutput($sformatf("mux_v%0d_addr", i), {24'd0, mem_addr}, {24'd0, vecs[i].exp_addr});
        checkOutput($sformatf("mux_v%0d_data", i), {24'd0, mem_data}, {24'd0, vecs[i].exp_data});
        checkOutput($sformatf("mux_v%0d_wren", i), {31'd0, mem_wren}, {31'd0, vecs[i].exp_wren});
      end
    end
  endtask

  task automatic runSearch(input string name, input logic [23:0] key, input int exp_rounds,
                           input logic exp_success, input logic [23:0] exp_key);
    int sr0, q0, cyc, n;
    bit order_ok;
    sr0 = sr_count;
    q0  = order_q.size();
    pass_key = key;
    stub_en  = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    checkOutput({name, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_success"}, {31'd0, success}, {31'd0, exp_success});
    checkOutput({name, "_key"}, {8'd0, secret_key}, {8'd0, exp_key});
    checkOutput({name, "_sub_resets"}, sr_count - sr0, exp_rounds);
    n = order_q.size() - q0;
    checkOutput({name, "_start_count"}, n, 3 * exp_rounds);
    order_ok = 1'b1;
    for (int j = 0; j < n; j++) if (order_q[q0 + j] != (j % 3)) order_ok = 1'b0;
    checkOutput({name, "_start_order"}, {31'd0, order_ok}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    vecs[0] = '{0, 3'b111, {8'hC3, 8'h55, 8'h11}, {8'hCC, 8'hBB, 8'hAA}, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{0, 3'b001, {8'h01, 8'h02, 8'h03}, {8'h04, 8'h05, 8'h06}, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{1, 3'b001, {8'hC3, 8'h55, 8'h11}, {8'hCC, 8'hBB, 8'hAA}, 8'h11, 8'hAA, 1'b1};
    vecs[3] = '{1, 3'b110, {8'hC3, 8'h55, 8'h11}, {8'hCC, 8'hBB, 8'hAA}, 8'h11, 8'hAA, 1'b0};
    vecs[4] = '{1, 3'b000, {8'h00, 8'h00, 8'h7E}, {8'h00, 8'h00, 8'h5A}, 8'h7E, 8'h5A, 1'b0};
    vecs[5] = '{2, 3'b100, {8'hC3, 8'h55, 8'h11}, {8'hCC, 8'hBB, 8'hAA}, 8'hC3, 8'hCC, 1'b1};
    vecs[6] = '{2, 3'b011, {8'hF0, 8'h55, 8'h11}, {8'h0F, 8'hBB, 8'hAA}, 8'hF0, 8'h0F, 1'b0};
    vecs[7] = '{2, 3'b111, {8'hFF, 8'h55, 8'h11}, {8'h80, 8'hBB, 8'hAA}, 8'hFF, 8'h80, 1'b1};

    reset_n = 1'b0; start = 1'b0; man_done = 3'b000; man_pass = 1'b0;
    stage_addr = '0; stage_data = '0; stage_wren = '0;
    stub_en = 1'b0; pass_key = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_success", {31'd0, success}, 32'd0);
    checkOutput("rst_sub_reset", {31'd0, sub_reset}, 32'd0);
    checkOutput("rst_stage_start", {29'd0, stage_start}, 32'd0);
    checkOutput("rst_key", {8'd0, secret_key}, 32'd0);
    checkOutput("rst_mem_wren", {31'd0, mem_wren}, 32'd0);
    checkOutput("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
`ifdef STAGE_TIMEOUT_EN
    checkOutput("rst_error", {31'd0, error}, 32'd0);
`endif
    runPhase(0);

    // Hand-driven round: sub_reset, then init, then ksa, then prga.
    @(negedge clk); start = 1'b1; stage_wren = 3'b000;
    @(negedge clk); start = 1'b0; #1;
    checkOutput("sub_reset_pulse", {31'd0, sub_reset}, 32'd1);
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    checkOutput("no_start_in_sub_reset", {29'd0, stage_start}, 32'd0);
    @(negedge clk); #1;
    checkOutput("init_go", {29'd0, stage_start}, 32'd1);
    runPhase(1);

    // A ksa done pulse during INIT_WAIT must not advance the controller.
    @(negedge clk); man_done = 3'b010; stage_wren = 3'b010; stage_addr = {8'hC3, 8'h55, 8'h11};
    @(negedge clk); #1;
    checkOutput("ksa_done_ignored", {29'd0, stage_start}, 32'd0);
    checkOutput("init_grant_held_addr", {24'd0, mem_addr}, 32'h11);
    checkOutput("init_grant_held_wren", {31'd0, mem_wren}, 32'd0);
    man_done = 3'b001;
    @(negedge clk); #1;
    checkOutput("ksa_go", {29'd0, stage_start}, 32'd2);
    checkOutput("ksa_grant_addr", {24'd0, mem_addr}, 32'h55);
    checkOutput("ksa_grant_wren", {31'd0, mem_wren}, 32'd1);
    man_done = 3'b011;
    @(negedge clk); #1;
    checkOutput("stale_done_in_go", {29'd0, stage_start}, 32'd0);
    @(negedge clk); #1;
    checkOutput("prga_go", {29'd0, stage_start}, 32'd4);
    runPhase(2);
    @(negedge clk); man_done = 3'b111; man_pass = 1'b0;
    @(negedge clk); man_done = 3'b000; stage_wren = 3'b111; #1;
    checkOutput("check_no_grant_wren", {31'd0, mem_wren}, 32'd0);
    checkOutput("check_no_grant_addr", {24'd0, mem_addr}, 32'd0);
    checkOutput("check_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); #1;
    checkOutput("next_sub_reset", {31'd0, sub_reset}, 32'd1);
    checkOutput("key_increment", {8'd0, secret_key}, 32'd1);
    @(negedge clk); #1;
    checkOutput("init_go_round2", {29'd0, stage_start}, 32'd1);
    man_done = 3'b001;
    @(negedge clk);
    @(negedge clk); #1;
    checkOutput("ksa_go_round2", {29'd0, stage_start}, 32'd2);
    man_done = 3'b000;
    @(negedge clk); #1;
    checkOutput("ksa_wait_wren", {31'd0, mem_wren}, 32'd1);
    reset_n = 1'b0; #1;
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_rst_wren", {31'd0, mem_wren}, 32'd0);
    checkOutput("async_rst_key", {8'd0, secret_key}, 32'd0);
    @(negedge clk); reset_n = 1'b1; stage_wren = 3'b000;
    @(negedge clk); #1;
    checkOutput("no_restart_busy", {31'd0, busy}, 32'd0);
    checkOutput("no_restart_start", {29'd0, stage_start}, 32'd0);

    // Full searches driven by the stub stages.
    runSearch("found_k0", 24'd0, 1, 1'b1, 24'd0);
    runSearch("found_k5", 24'd5, 6, 1'b1, 24'd5);
    runSearch("exhaust", 24'hFFFFFF, 8, 1'b0, 24'd7);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("exhaust_done_holds", {31'd0, done}, 32'd1);
    checkOutput("exhaust_key_holds", {8'd0, secret_key}, 32'd7);

`ifdef STAGE_TIMEOUT_EN
    // Init never finishes, so the watchdog aborts after 100 WAIT cycles.
    stub_en = 1'b0; man_done = 3'b000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); #1;
    checkOutput("wd_init_go", {29'd0, stage_start}, 32'd1);
    repeat (100) @(negedge clk);
    #1;
    checkOutput("wd_not_yet", {31'd0, error}, 32'd0);
    @(negedge clk); #1;
    checkOutput("wd_error", {31'd0, error}, 32'd1);
    checkOutput("wd_done", {31'd0, done}, 32'd1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    checkOutput("wd_start_clears", {31'd0, error}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
